// File: rtl/mux_n_1_stream.sv
// N:1 registered valid/ready stream mux, fixed-select or round-robin.
// Define MUX_SRC_TAG_EN to add the out_src channel-index output.
module mux_n_1_stream #(
    parameter int W    = 4,
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    input  logic            out_ready
`ifdef MUX_SRC_TAG_EN
    ,
    output logic [SELW-1:0] out_src
`endif
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] grant;
    logic [SELW-1:0] pnext;
    logic [W-1:0]    gdata;
    logic            hit;
    logic            load;

    always_comb begin
        int idx;
        grant = '0;
        hit   = 1'b0;
        idx   = 0;
        if (!mode) begin
            if ((int'(sel) < N) && in_valid[sel]) begin
                hit   = 1'b1;
                grant = sel;
            end
        end else begin
            // Rotating search starting at ptr; first valid wins.
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (!hit && in_valid[idx]) begin
                    hit   = 1'b1;
                    grant = SELW'(idx);
                end
            end
        end
    end

    always_comb begin
        load     = en && hit && (!out_valid || out_ready);
        in_ready = '0;
        if (load) in_ready[grant] = 1'b1;
        gdata = in_data[int'(grant)*W +: W];
        pnext = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= gdata;
            if (mode) ptr <= pnext;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_SRC_TAG_EN
    always_ff @(posedge clk) begin
        if (rst)       out_src <= '0;
        else if (load) out_src <= grant;
    end
`endif

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Scoreboard bench for mux_n_1_stream (N=4 main instance, N=3 for
// out-of-range select).
module tb_mux_n_1_stream;
    localparam int W = 4;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst, en, mode, out_ready;
    logic [1:0]    sel;
    logic [N-1:0]  in_valid, in_ready;
    logic [N*W-1:0] in_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [2:0]    in_valid3, in_ready3;
    logic [11:0]   in_data3;
    logic          out_valid3;
    logic [W-1:0]  out_data3;
`ifdef MUX_SRC_TAG_EN
    logic [1:0]    out_src, out_src3;
`endif

    int nchk = 0;
    int nerr = 0;

    logic [W-1:0] q[$];
    logic         m_valid;
    logic [1:0]   m_ptr;

    always #5 clk = ~clk;

    mux_n_1_stream #(.W(W), .N(N), .SELW(2)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef MUX_SRC_TAG_EN
        , .out_src(out_src)
`endif
    );

    mux_n_1_stream #(.W(W), .N(3), .SELW(2)) dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready)
`ifdef MUX_SRC_TAG_EN
        , .out_src(out_src3)
`endif
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int mgrant();
        int idx;
        if (!mode) begin
            if (in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            idx = (int'(m_ptr) + k) % N;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check handshake against model, scoreboard, advance model.
    task automatic cyc();
        int g;
        logic ld;
        logic [W-1:0] e;
        @(negedge clk);
        g  = mgrant();
        ld = en && (g >= 0) && (!m_valid || out_ready);
        if (!rst) check("in_ready", 32'(in_ready), ld ? 32'(1 << g) : 32'd0);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid && out_ready) begin
            if (q.size() == 0) check("sb_empty", 32'(out_data), 32'hffff);
            else begin
                e = q.pop_front();
                check("sb_data", 32'(out_data), 32'(e));
            end
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = '0;
            q.delete();
        end else if (ld) begin
            m_valid = 1'b1;
            q.push_back(in_data[g*W +: W]);
            if (mode) m_ptr = 2'((g + 1) % N);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [W-1:0] rr_exp [6];
        rr_exp = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 4'h1};
        rst = 1'b1; en = 1'b1; mode = 1'b0; sel = '0;
        in_valid = '0; in_data = '0; out_ready = 1'b1;
        in_valid3 = '0; in_data3 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; m_valid = 1'b0; m_ptr = '0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);

        // fixed select sel=1
        sel = 2'd1; in_valid = 4'b0010; in_data = {4'h3, 4'h2, 4'h5, 4'h0};
        #1 check("fix_rdy", 32'(in_ready), 32'b0010);
        cyc();
        in_valid = '0;
        check("fix_valid", 32'(out_valid), 32'd1);
        check("fix_data", 32'(out_data), 32'h5);
`ifdef MUX_SRC_TAG_EN
        check("fix_src", 32'(out_src), 32'd1);
`endif
        cyc();

        // round-robin, all valid
        mode = 1'b1; in_valid = 4'b1111; in_data = {4'h3, 4'h2, 4'h1, 4'h0};
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("rr_data", 32'(out_data), 32'(rr_exp[i]));
        end
        in_valid = '0;
        cyc();

        // backpressure
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
        in_data = {4'h3, 4'hA, 4'h1, 4'h0};
        cyc();
        check("bp_load", 32'(out_data), 32'hA);
        out_ready = 1'b0; in_data = {4'h3, 4'hB, 4'h1, 4'h0};
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("bp_hold", 32'(out_data), 32'hA);
        end
        out_ready = 1'b1;
        cyc();
        check("bp_next_v", 32'(out_valid), 32'd1);
        check("bp_next_d", 32'(out_data), 32'hB);
        in_valid = '0;
        cyc();

        // enable gating
        sel = 2'd0; in_valid = 4'b0001; in_data = {4'h3, 4'h2, 4'h1, 4'hC};
        out_ready = 1'b0;
        cyc();
        check("en_load", 32'(out_data), 32'hC);
        en = 1'b0;
        cyc();
        out_ready = 1'b1;
        #1 check("en_rdy", 32'(in_ready), 32'd0);
        cyc();
        check("en_drain", 32'(out_valid), 32'd0);
        en = 1'b1; in_valid = '0;

        // out-of-range select on N=3
        sel = 2'd3; in_valid3 = 3'b111; in_data3 = {4'h6, 4'h5, 4'h4};
        #1 check("n3_rdy", 32'(in_ready3), 32'd0);
        cyc();
        check("n3_nogrant", 32'(out_valid3), 32'd0);
        sel = 2'd2;
        #1 check("n3_rdy2", 32'(in_ready3), 32'b100);
        cyc();
        check("n3_valid", 32'(out_valid3), 32'd1);
        check("n3_data", 32'(out_data3), 32'h6);
        in_valid3 = '0;
        cyc();

        // reset mid-operation with ptr at 2
        mode = 1'b1; in_valid = 4'b0010; in_data = {4'h3, 4'h2, 4'h7, 4'h0};
        cyc();
        check("pre_rst_d", 32'(out_data), 32'h7);
        rst = 1'b1; out_ready = 1'b0; in_valid = 4'b1111;
        cyc();
        check("rst_mid_v", 32'(out_valid), 32'd0);
        check("rst_mid_d", 32'(out_data), 32'd0);
        rst = 1'b0; out_ready = 1'b1; in_valid = 4'b1010;
        in_data = {4'h4, 4'h3, 4'h9, 4'h1};
        cyc();
        check("post_rst", 32'(out_data), 32'h9);
        in_valid = '0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
